// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - saturating accumulator of signed Booth products with valid/ready result handoff
module product_accumulator #(
  parameter int WIDTH = 16,
  parameter int COUNT = 8,
  parameter int GUARD = 4,
  localparam int ACC_W = 2 * WIDTH + GUARD,
  localparam int CW    = $clog2(COUNT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prod_valid,
  input  logic [2*WIDTH-1:0] product,
  input  logic               clear,
  output logic [ACC_W-1:0]   acc_out,
  output logic               acc_valid,
  input  logic               acc_ready,
  output logic               overflow,
  output logic               dropped,
  output logic               busy
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state, state_d;
  logic [ACC_W-1:0] acc, acc_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             prev_valid;
  logic             accept;
  logic [ACC_W-1:0] acc_out_d;
  logic             acc_valid_d, overflow_d, dropped_d, busy_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum_wide;
  logic             add_ovf;
  logic [ACC_W-1:0] sat_sum;

  // A held-high done level produces exactly one accept on its rising edge.
  assign accept = prod_valid & ~prev_valid;

  // One guarded add per accept; an extra bit exposes signed overflow for saturation.
  assign prod_ext = ACC_W'($signed(product));
  assign sum_wide = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
  assign add_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  assign sat_sum  = add_ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];

  // Next-state and datapath updates; clear outranks everything except reset.
  always_comb begin
    state_d     = state;
    acc_d       = acc;
    cnt_d       = cnt;
    acc_out_d   = acc_out;
    acc_valid_d = acc_valid;
    overflow_d  = overflow;
    dropped_d   = dropped;
    busy_d      = busy;
    if (clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      acc_valid_d = 1'b0;
      overflow_d  = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc_d      = sat_sum;
            cnt_d      = cnt + CW'(1);
            busy_d     = 1'b1;
            overflow_d = overflow | add_ovf;
            if (cnt == CW'(COUNT - 1)) begin
              acc_out_d   = sat_sum;
              acc_valid_d = 1'b1;
              state_d     = HOLD;
            end
          end
        end
        HOLD: begin
          // Products arriving while a result waits are lost, including in the handoff cycle.
          if (accept) dropped_d = 1'b1;
          if (acc_valid && acc_ready) begin
            acc_valid_d = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            overflow_d  = 1'b0;
            busy_d      = 1'b0;
            state_d     = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ACCUM;
      acc        <= '0;
      cnt        <= '0;
      prev_valid <= 1'b0;
      acc_out    <= '0;
      acc_valid  <= 1'b0;
      overflow   <= 1'b0;
      dropped    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      acc        <= acc_d;
      cnt        <= cnt_d;
      prev_valid <= prod_valid;
      acc_out    <= acc_out_d;
      acc_valid  <= acc_valid_d;
      overflow   <= overflow_d;
      dropped    <= dropped_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - self-checking bench for product_accumulator
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // A: COUNT=4 GUARD=2
  logic        a_pv, a_clear, a_ready, a_valid, a_ov, a_drop, a_busy;
  logic [31:0] a_prod;
  logic [33:0] a_out;
  // B: COUNT=1 GUARD=2
  logic        b_pv, b_clear, b_ready, b_valid, b_ov, b_drop, b_busy;
  logic [31:0] b_prod;
  logic [33:0] b_out;
  // C: COUNT=2 GUARD=0
  logic        c_pv, c_clear, c_ready, c_valid, c_ov, c_drop, c_busy;
  logic [31:0] c_prod;
  logic [31:0] c_out;

  product_accumulator #(.WIDTH(16), .COUNT(4), .GUARD(2)) u_a (
    .clk(clk), .rst_n(rst_n), .prod_valid(a_pv), .product(a_prod), .clear(a_clear),
    .acc_out(a_out), .acc_valid(a_valid), .acc_ready(a_ready), .overflow(a_ov),
    .dropped(a_drop), .busy(a_busy));

  product_accumulator #(.WIDTH(16), .COUNT(1), .GUARD(2)) u_b (
    .clk(clk), .rst_n(rst_n), .prod_valid(b_pv), .product(b_prod), .clear(b_clear),
    .acc_out(b_out), .acc_valid(b_valid), .acc_ready(b_ready), .overflow(b_ov),
    .dropped(b_drop), .busy(b_busy));

  product_accumulator #(.WIDTH(16), .COUNT(2), .GUARD(0)) u_c (
    .clk(clk), .rst_n(rst_n), .prod_valid(c_pv), .product(c_prod), .clear(c_clear),
    .acc_out(c_out), .acc_valid(c_valid), .acc_ready(c_ready), .overflow(c_ov),
    .dropped(c_drop), .busy(c_busy));

  // Reference: add as plain integers, clamp into the accw-bit signed range.
  function automatic longint sat_add(input longint a, input longint p, input int accw, output bit ov);
    longint mx, mn, s;
    mx = (longint'(1) <<< (accw - 1)) - 1;
    mn = -(longint'(1) <<< (accw - 1));
    s  = a + p;
    ov = 1'b0;
    if (s > mx) begin s = mx; ov = 1'b1; end
    if (s < mn) begin s = mn; ov = 1'b1; end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input logic [31:0] p);
    a_prod = p; a_pv = 1'b1; tick();
    a_pv = 1'b0; tick();
  endtask

  task automatic pulse_c(input logic [31:0] p);
    c_prod = p; c_pv = 1'b1; tick();
    c_pv = 1'b0; tick();
  endtask

  task automatic handshake_c();
    c_ready = 1'b1; tick();
    c_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_out, a_valid, a_ov, a_drop, a_busy} !== 38'd0) begin
      errors++; $display("FAIL reset_a: got out=%0h v=%b ov=%b d=%b b=%b, want all 0", a_out, a_valid, a_ov, a_drop, a_busy);
    end
    checks++;
    if ({b_valid, c_valid, c_out} !== 34'd0) begin
      errors++; $display("FAIL reset_bc: got bv=%b cv=%b cout=%0h, want 0", b_valid, c_valid, c_out);
    end
  endtask

  task automatic test_basic();
    logic [33:0] held;
    pulse_a(32'd15); pulse_a(-32'sd14); pulse_a(32'd100);
    checks++;
    if (a_valid !== 1'b0 || a_busy !== 1'b1) begin
      errors++; $display("FAIL basic_pre: got v=%b busy=%b, want v=0 busy=1", a_valid, a_busy);
    end
    a_prod = 32'hFFFF_FFFF; a_pv = 1'b1; tick();
    checks++;
    if (a_valid !== 1'b1 || a_out !== 34'd100 || a_ov !== 1'b0) begin
      errors++; $display("FAIL basic_sum: got v=%b out=%0d ov=%b, want v=1 out=100 ov=0", a_valid, $signed(a_out), a_ov);
    end
    a_pv = 1'b0;
    held = a_out;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (a_valid !== 1'b1 || a_out !== 34'd100) begin
        errors++; $display("FAIL basic_hold: cycle %0d got v=%b out=%0h held=%0h, want v=1 out=100", i, a_valid, a_out, held);
      end
    end
    a_ready = 1'b1; tick(); a_ready = 1'b0;
    checks++;
    if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL basic_handoff: got v=%b busy=%b, want 0 0", a_valid, a_busy);
    end
  endtask

  task automatic test_sticky_level();
    b_prod = 32'd7; b_pv = 1'b1; tick();
    checks++;
    if (b_valid !== 1'b1 || b_out !== 34'd7) begin
      errors++; $display("FAIL sticky_first: got v=%b out=%0d, want v=1 out=7", b_valid, b_out);
    end
    b_ready = 1'b1; tick(); b_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b_prod = 32'd9; tick();
      checks++;
      if (b_valid !== 1'b0 || b_drop !== 1'b0) begin
        errors++; $display("FAIL sticky_level: cycle %0d got v=%b dropped=%b, want 0 0", i, b_valid, b_drop);
      end
    end
    b_pv = 1'b0; tick();
    b_pv = 1'b1; tick();
    checks++;
    if (b_valid !== 1'b1 || b_out !== 34'd9) begin
      errors++; $display("FAIL sticky_rearm: got v=%b out=%0d, want v=1 out=9", b_valid, b_out);
    end
    b_pv = 1'b0; b_ready = 1'b1; tick(); b_ready = 1'b0;
  endtask

  task automatic test_overflow();
    pulse_c(32'h4000_0000); pulse_c(32'h4000_0000);
    checks++;
    if (c_valid !== 1'b1 || c_out !== 32'h7FFF_FFFF || c_ov !== 1'b1) begin
      errors++; $display("FAIL ovf_pos: got v=%b out=%0h ov=%b, want 1 7fffffff 1", c_valid, c_out, c_ov);
    end
    handshake_c();
    pulse_c(32'd1); pulse_c(32'd2);
    checks++;
    if (c_valid !== 1'b1 || c_out !== 32'd3 || c_ov !== 1'b0) begin
      errors++; $display("FAIL ovf_recover: got v=%b out=%0h ov=%b, want 1 3 0", c_valid, c_out, c_ov);
    end
    handshake_c();
    pulse_c(32'h8000_0000); pulse_c(32'hFFFF_FFFF);
    checks++;
    if (c_valid !== 1'b1 || c_out !== 32'h8000_0000 || c_ov !== 1'b1) begin
      errors++; $display("FAIL ovf_neg: got v=%b out=%0h ov=%b, want 1 80000000 1", c_valid, c_out, c_ov);
    end
    handshake_c();
  endtask

  task automatic test_backpressure();
    pulse_c(32'd2); pulse_c(32'd3);
    pulse_c(32'd40);
    checks++;
    if (c_valid !== 1'b1 || c_out !== 32'd5 || c_drop !== 1'b1) begin
      errors++; $display("FAIL bp_drop: got v=%b out=%0d dropped=%b, want 1 5 1", c_valid, c_out, c_drop);
    end
    handshake_c();
    pulse_c(32'd6); pulse_c(32'd7);
    checks++;
    if (c_valid !== 1'b1 || c_out !== 32'd13) begin
      errors++; $display("FAIL bp_next: got v=%b out=%0d, want 1 13", c_valid, c_out);
    end
    handshake_c();
  endtask

  task automatic test_clear_and_reset();
    pulse_a(32'd1000); pulse_a(32'd2000);
    a_clear = 1'b1; tick(); a_clear = 1'b0;
    checks++;
    if (a_busy !== 1'b0 || a_valid !== 1'b0) begin
      errors++; $display("FAIL clear_busy: got busy=%b v=%b, want 0 0", a_busy, a_valid);
    end
    pulse_a(32'd1); pulse_a(32'd2); pulse_a(32'd3); pulse_a(32'd4);
    checks++;
    if (a_valid !== 1'b1 || a_out !== 34'd10) begin
      errors++; $display("FAIL clear_sum: got v=%b out=%0d, want 1 10", a_valid, a_out);
    end
    pulse_c(32'd1); pulse_c(32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++;
    if (c_valid !== 1'b0 || c_drop !== 1'b0 || c_out !== 32'd0 || a_valid !== 1'b0 || a_out !== 34'd0) begin
      errors++; $display("FAIL reset_hold: got cv=%b cd=%b cout=%0h av=%b aout=%0h, want all 0", c_valid, c_drop, c_out, a_valid, a_out);
    end
  endtask

  task automatic test_random();
    longint exp_sum;
    bit     exp_ov, step_ov, exp_drop;
    logic [31:0] p;
    do_reset();
    exp_drop = 1'b0;
    for (int r = 0; r < 20; r++) begin
      exp_sum = 0; exp_ov = 1'b0;
      for (int k = 0; k < 4; k++) begin
        p = $urandom;
        if ($urandom_range(0, 3) == 0) p = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
        exp_sum = sat_add(exp_sum, longint'($signed(p)), 34, step_ov);
        exp_ov  = exp_ov | step_ov;
        a_prod = p; a_pv = 1'b1; tick();
        a_pv = 1'b0;
        for (int g = $urandom_range(1, 3); g > 0; g--) tick();
      end
      if ($urandom_range(0, 2) == 0) begin
        pulse_a($urandom);
        exp_drop = 1'b1;
      end
      checks++;
      if (a_valid !== 1'b1 || a_out !== 34'(exp_sum) || a_ov !== exp_ov || a_drop !== exp_drop) begin
        errors++; $display("FAIL random_%0d: got v=%b out=%0h ov=%b d=%b, want 1 %0h %b %b", r, a_valid, a_out, a_ov, a_drop, 34'(exp_sum), exp_ov, exp_drop);
      end
      a_ready = 1'b1; tick(); a_ready = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_pv = 0; a_prod = 0; a_clear = 0; a_ready = 0;
    b_pv = 0; b_prod = 0; b_clear = 0; b_ready = 0;
    c_pv = 0; c_prod = 0; c_clear = 0; c_ready = 0;
    test_reset();
    test_basic();
    test_sticky_level();
    test_overflow();
    test_backpressure();
    test_clear_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
